serial_mag_comp: RTL

Multi-cycle magnitude comparator for operands wider than the combinational comparators. It consumes two WIDTH-bit unsigned operands and scans them MSB-first, two bits per clock, through a 2-bit digit comparator. It accumulates a running greater/less/equal verdict and reports one registered one-hot result with a done pulse. It sits downstream of operand registers and upstream of any logic that needs agb/alb/aeb for wide words.

---
 rtl/serial_mag_comp_pkg.sv | 23 ++
 rtl/serial_mag_comp_comp_digit.sv | 20 ++
 rtl/serial_mag_comp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_mag_comp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_mag_comp_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One-hot verdict, bit order {agb, alb, aeb}
  typedef enum logic [2:0] {
    GT = 3'b100,
    LT = 3'b010,
    EQ = 3'b001
  } verdict_e;

  // Number of 2-bit digits in a WIDTH-bit operand
  function automatic int unsigned n_digits(input int unsigned width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/serial_mag_comp_comp_digit.sv
// Combinational 2-bit unsigned comparator producing a one-hot verdict.
module comp_digit
  import serial_mag_comp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output verdict_e           verdict_c
);

  // Digit-level greater/less/equal decision
  always_comb begin
    verdict_c = EQ;
    if (a_i > b_i) begin
      verdict_c = GT;
    end else if (a_i < b_i) begin
      verdict_c = LT;
    end
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, two bits per clock.
// Optional build macro: EARLY_EXIT_EN -- finish on the first unequal digit.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);

  localparam int unsigned N     = n_digits(WIDTH);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("serial_mag_comp: WIDTH must be even and at least 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  verdict_e         verd_q, verd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;

  verdict_e         dig_verd_c;
  verdict_e         verd_next_c;
  logic             finish_c;

  // Compare the current top digit of both shift registers
  comp_digit u_comp_digit (
    .a_i       (a_sh_q[WIDTH-1 -: DIGIT_W]),
    .b_i       (b_sh_q[WIDTH-1 -: DIGIT_W]),
    .verdict_c (dig_verd_c)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    verd_d      = verd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_d       = res_q;
    verd_next_c = (verd_q == EQ) ? dig_verd_c : verd_q;
`ifdef EARLY_EXIT_EN
    finish_c    = (cnt_q == '0) || (verd_next_c != EQ);
`else
    finish_c    = (cnt_q == '0);
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = CNT_W'(N - 1);
          verd_d  = EQ;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        verd_d = verd_next_c;
        a_sh_d = a_sh_q << DIGIT_W;
        b_sh_d = b_sh_q << DIGIT_W;
        cnt_d  = cnt_q - CNT_W'(1);
        if (finish_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = verd_next_c;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      verd_q  <= EQ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      verd_q  <= verd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign agb  = res_q[2];
  assign alb  = res_q[1];
  assign aeb  = res_q[0];

endmodule
